seq_bcd_encoder: RTL
====================

// Module: seq_bcd_encoder
// PURPOSE
//  Iterative (one bit per clock) double-dabble binary-to-BCD converter.
//  - Successor to the combinational display encoder.
//  - Generalised in input width, digit count and signedness.
//  - Adds a start/done handshake, overflow detection and registered outputs.
//  - Sits between processor result registers and the seven-segment digit mux.
// PARAMETERS
//  WIDTH   8  input word width in bits (>=2)
//  DIGITS  3  number of BCD output digits (>=1)
//  SIGNED  1  1: input is two's complement; 0: input is unsigned
// PORTS
//  clk       in   1         rising-edge clock
//  rst       in   1         asynchronous, active-high reset
//  start     in   1         request conversion of number; sampled only in IDLE
//  number    in   WIDTH     value to convert; sampled on the accepted start edge
//  busy      out  1         high while a conversion is in progress
//  done      out  1         one-cycle pulse when outputs are updated
//  sign      out  4         15 = minus, 14 = blank (non-negative)
//  digits    out  4*DIGITS  BCD digits; [3:0] = ones, [7:4] = tens, ...
//  overflow  out  1         magnitude >= 10**DIGITS for the last conversion
// BEHAVIOUR
//  Reset (async, any state):
//  - state=IDLE, busy=0, done=0, sign=14, digits=0, overflow=0.
//  - Any in-flight conversion is discarded.
//  Magnitude:
//  - SIGNED=1 and number[WIDTH-1]=1: mag = -number, held as WIDTH-bit unsigned.
//    Most-negative input is exact, e.g. -128 -> 128.
//  - Otherwise mag = number.
//  FSM:
//  - IDLE: start=1 -> latch mag and the negative flag, clear scratch digits,
//    clear the sticky ovf flag, cnt=WIDTH-1, go to SHIFT, busy=1.
//  - SHIFT: each cycle, every scratch digit >=5 gets +3; then {digits,mag}
//    shift left by 1. Any 1 shifted out of the top digit sets sticky ovf.
//    When cnt==0, go to DONE; otherwise decrement cnt.
//  - DONE (one cycle): load the output registers digits, sign and overflow;
//    done=1; busy=0; go to IDLE.
//  Timing:
//  - start accepted at edge 0 -> done high for exactly one cycle after edge
//    WIDTH+1. Throughput: one conversion per WIDTH+2 cycles.
//  - start while busy (SHIFT or DONE) is ignored, not queued.
//  - start may be high in the same cycle done is high; it is accepted on the
//    next IDLE edge.
//  - Outputs change only in DONE and hold their value between conversions.
//  Overflow:
//  - digits show the low DIGITS decimal digits of the magnitude (mod 10**DIGITS).
//  - overflow=1 until the next conversion completes.
//  sign:
//  - 14 for zero and for positive values; always 14 when SIGNED=0.
// CONFIGURATION
//  BCD_LZ_BLANK_EN defined:
//  - In DONE, leading zero digits above the ones digit are replaced by 14
//    (blank). The ones digit is never blanked.
//  - sign=15 stays in the sign output and is not moved next to the digits.
//  - Blanking is a small combinational stage before the output registers;
//    latency is unchanged.
//  BCD_LZ_BLANK_EN undefined:
//  - Digits are plain BCD 0-9, including leading zeros.
// TESTING
//  1 W=8,D=3,S=1: number=8'h80 -> after WIDTH+2 clks: done pulse, sign=15,
//    digits=12'h128, overflow=0
//  2 number=8'd0 -> sign=14, digits=12'h000 (LZ_BLANK_EN: 12'hEE0)
//  3 number=8'd127, then start pulsed 3 clks later mid-conversion -> single done,
//    digits=12'h127; second start ignored, busy low after done
//  4 W=8,D=2,S=0: number=8'd255 -> digits=8'h55, overflow=1;
//    next number=8'd99 -> digits=8'h99, overflow=0
//  5 rst asserted at cycle 4 of a conversion of -5 -> immediate busy=0,
//    digits=0, sign=14; no done; new start converts -5 -> sign=15, 12'h005
//  6 back-to-back: start held high continuously -> done every WIDTH+2 clks

Source files
------------

// File: rtl/seq_bcd_encoder_if.sv
// Handshake and result bus for seq_bcd_encoder.
// master: the requester (drives start/number); slave: the encoder.
interface seq_bcd_encoder_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      number;
    logic                  busy;
    logic                  done;
    logic [3:0]            sign;
    logic [4*DIGITS-1:0]   digits;
    logic                  overflow;

    modport master (
        output start, number,
        input  busy, done, sign, digits, overflow
    );

    modport slave (
        input  start, number,
        output busy, done, sign, digits, overflow
    );
endinterface

// File: rtl/seq_bcd_encoder.sv
// seq_bcd_encoder: iterative double-dabble binary-to-BCD converter.
// One input bit is consumed per clock; a conversion takes WIDTH+2 cycles
// from accepted start to the cycle after the done pulse.
// Optional feature macro: BCD_LZ_BLANK_EN (blank leading zero digits as 14).
// The interface instance must use the same WIDTH/DIGITS as this module.
module seq_bcd_encoder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3,
    parameter bit          SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seq_bcd_encoder_if.slave  bus
);
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic            neg_q, neg_d;
    logic [BW-1:0]   scr_q, scr_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [3:0]      sign_q, sign_d;
    logic [BW-1:0]   dig_q, dig_d;
    logic            ovfo_q, ovfo_d;

    logic            neg_in;
    logic [WIDTH-1:0] mag_in;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   dig_fmt;
`ifdef BCD_LZ_BLANK_EN
    logic            lead;
`endif

    // Input magnitude; the most-negative value negates to itself, which is
    // exactly its magnitude when read as unsigned.
    always_comb begin
        neg_in = SIGNED && bus.number[WIDTH-1];
        mag_in = neg_in ? ('0 - bus.number) : bus.number;
    end

    // Add-3 correction on every scratch digit that is 5 or more.
    always_comb begin
        adj = scr_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Output digit formatting applied when the result is registered.
    always_comb begin
        dig_fmt = scr_q;
`ifdef BCD_LZ_BLANK_EN
        lead = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (scr_q[4*i +: 4] == 4'd0)) begin
                dig_fmt[4*i +: 4] = 4'hE;
            end else begin
                lead = 1'b0;
            end
        end
`endif
    end

    // Next-state and datapath updates for the conversion FSM.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        scr_d   = scr_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sign_d  = sign_q;
        dig_d   = dig_q;
        ovfo_d  = ovfo_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mag_d   = mag_in;
                    neg_d   = neg_in;
                    scr_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(WIDTH - 1);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = {adj[BW-2:0], mag_q[WIDTH-1]};
                mag_d = {mag_q[WIDTH-2:0], 1'b0};
                ovf_d = ovf_q | adj[BW-1];
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                dig_d   = dig_fmt;
                sign_d  = neg_q ? 4'hF : 4'hE;
                ovfo_d  = ovf_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scratch datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q  <= '0;
            neg_q  <= 1'b0;
            scr_q  <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sign_q <= 4'hE;
            dig_q  <= '0;
            ovfo_q <= 1'b0;
        end else begin
            mag_q  <= mag_d;
            neg_q  <= neg_d;
            scr_q  <= scr_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            sign_q <= sign_d;
            dig_q  <= dig_d;
            ovfo_q <= ovfo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sign     = sign_q;
    assign bus.digits   = dig_q;
    assign bus.overflow = ovfo_q;

endmodule
